// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - 8N1 LSB-first UART transmitter fed by a byte FIFO
module uart_tx_fifo #(
    parameter int DELAY_FRAMES = 234,
    parameter int FIFO_AW      = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               uart_tx,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_count
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CW    = (DELAY_FRAMES > 1) ? $clog2(DELAY_FRAMES) : 1;
    localparam logic [CW-1:0]    LAST_CNT = CW'(DELAY_FRAMES - 1);
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state;
    logic [CW-1:0]        bit_cnt;
    logic [2:0]           bit_idx;
    logic [7:0]           shift_reg;
    logic [7:0]           mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr;
    logic [FIFO_AW-1:0]   rd_ptr;
    logic                 bit_end;
    logic                 push;
    logic                 pop;

    assign bit_end  = (bit_cnt == LAST_CNT);
    assign in_ready = (fifo_count != FULL_CNT);
    assign push     = in_valid && in_ready;
    // A pop starts the next frame: from idle, or straight out of the last stop-bit cycle.
    assign pop      = (fifo_count != '0) && ((state == IDLE) || (state == STOP && bit_end));
    assign busy     = (state != IDLE) || (fifo_count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (FIFO_AW + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (FIFO_AW + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            uart_tx   <= 1'b1;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift_reg <= mem[rd_ptr];
                        uart_tx   <= 1'b0;
                        bit_cnt   <= '0;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        uart_tx <= shift_reg[0];
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            uart_tx <= shift_reg[bit_idx + 3'd1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (pop) begin
                            shift_reg <= mem[rd_ptr];
                            uart_tx   <= 1'b0;
                            state     <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule
